// File: rtl/addsub_operand_ctrl.sv
// addsub_operand_ctrl: button/switch operand entry for the 2-bit addsub unit.
// Build option: define DEBOUNCE_EN to add per-button debounce counters.
module addsub_operand_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_data,
  input  logic       sw_mode,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [1:0] sum_in,
  input  logic       cout_in,
  output logic [1:0] op_a,
  output logic [1:0] op_b,
  output logic       op_m,
  output logic [1:0] result_s,
  output logic       result_c,
  output logic       result_valid,
  output logic [1:0] state_code
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // bit 0 = enter, bit 1 = clear
  logic [1:0] s1, s2, lvl, prev, pulse, warm;
  logic       enter_p, clear_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      warm <= '0;
    end else begin
      s1   <= {btn_clear, btn_enter};
      s2   <= s1;
      warm <= {warm[0], 1'b1};
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!s2[i])
          cnt[i] <= '0;
        else if (cnt[i] != CMAX)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lvl = '0;
    for (int i = 0; i < 2; i++)
      lvl[i] = (cnt[i] == CMAX);
  end
`else
  logic unused_dbc;
  assign unused_dbc = (DEBOUNCE_CYCLES > 0);
  assign lvl = s2;
`endif

  // prev holds high until the synchronizer has filled after reset, and
  // stays high while the button is still down, so a held button is inert
  always_ff @(posedge clk) begin
    if (reset)
      prev <= 2'b11;
    else if (warm[1])
      prev <= lvl | (prev & s2);
  end

  assign pulse   = lvl & ~prev;
  assign enter_p = pulse[0];
  assign clear_p = pulse[1];

  state_t     state, state_n;
  logic [1:0] a_n, b_n, rs_n;
  logic       m_n, rc_n, rv_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      op_m         <= 1'b0;
      result_s     <= '0;
      result_c     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      op_a         <= a_n;
      op_b         <= b_n;
      op_m         <= m_n;
      result_s     <= rs_n;
      result_c     <= rc_n;
      result_valid <= rv_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = op_a;
    b_n     = op_b;
    m_n     = op_m;
    rs_n    = result_s;
    rc_n    = result_c;
    rv_n    = result_valid;
    if (clear_p) begin
      state_n = IDLE;
      a_n     = '0;
      b_n     = '0;
      m_n     = 1'b0;
      rs_n    = '0;
      rc_n    = 1'b0;
      rv_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (enter_p) begin
          a_n     = sw_data;
          state_n = LOAD_B;
        end
        LOAD_B: if (enter_p) begin
          b_n     = sw_data;
          m_n     = sw_mode;
          state_n = EXEC;
        end
        EXEC: begin
          rs_n    = sum_in;
          rc_n    = cout_in;
          rv_n    = 1'b1;
          state_n = SHOW;
        end
        SHOW: if (enter_p) begin
          a_n     = sw_data;
          rv_n    = 1'b0;
          state_n = LOAD_B;
        end
      endcase
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_addsub_operand_ctrl.sv
// tb_addsub_operand_ctrl: directed vectors for addsub_operand_ctrl.
// A behavioural 2-bit add/subtract unit closes the loop on op_*/sum_in.
module tb_addsub_operand_ctrl;

`ifdef DEBOUNCE_EN
  localparam int DB     = 4;
  localparam int HOLD   = DB + 3;
  localparam int SETTLE = DB + 4;
`else
  localparam int HOLD   = 3;
  localparam int SETTLE = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw_data;
  logic       sw_mode;
  logic       btn_enter;
  logic       btn_clear;
  logic [1:0] sum_in;
  logic       cout_in;
  logic [1:0] op_a, op_b, result_s, state_code;
  logic       op_m, result_c, result_valid;
  logic [2:0] alu;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  assign alu = op_m ? ({1'b0, op_a} - {1'b0, op_b})
                    : ({1'b0, op_a} + {1'b0, op_b});
  assign sum_in  = alu[1:0];
  assign cout_in = alu[2];

  addsub_operand_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sw_data      (sw_data),
    .sw_mode      (sw_mode),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .sum_in       (sum_in),
    .cout_in      (cout_in),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_m         (op_m),
    .result_s     (result_s),
    .result_c     (result_c),
    .result_valid (result_valid),
    .state_code   (state_code)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic ent, input logic clr);
    @(negedge clk);
    btn_enter = ent;
    btn_clear = clr;
    repeat (HOLD) @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  // enter from LOAD_B, then check EXEC->SHOW one cycle at a time
  task automatic exec_watch(input string tag,
                            input logic [1:0] b,
                            input logic m,
                            input logic [1:0] s,
                            input logic c);
    bit seen = 0;
    @(negedge clk);
    btn_enter = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == HOLD - 1) btn_enter = 1'b0;
      if (state_code == 2'b10) begin
        seen = 1;
        break;
      end
    end
    btn_enter = 1'b0;
    chk({tag, "_exec_seen"}, 8'(seen), 8'd1);
    chk({tag, "_opb"}, 8'(op_b), 8'(b));
    chk({tag, "_opm"}, 8'(op_m), 8'(m));
    chk({tag, "_v_early"}, 8'(result_valid), 8'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 8'(result_valid), 8'd1);
    chk({tag, "_s"}, 8'(result_s), 8'(s));
    chk({tag, "_c"}, 8'(result_c), 8'(c));
    chk({tag, "_show"}, 8'(state_code), 8'h3);
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    btn_enter = 1'b1;
    btn_clear = 1'b0;
    sw_data   = 2'b11;
    sw_mode   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_opa", 8'(op_a), 8'd0);
    chk("rst_opb", 8'(op_b), 8'd0);
    chk("rst_opm", 8'(op_m), 8'd0);
    chk("rst_rs", 8'(result_s), 8'd0);
    chk("rst_rc", 8'(result_c), 8'd0);
    chk("rst_rv", 8'(result_valid), 8'd0);
    chk("rst_state", 8'(state_code), 8'h0);
    btn_enter = 1'b0;
    repeat (SETTLE) @(negedge clk);

    // 01 + 10 = 11, no carry
    sw_mode = 1'b0;
    sw_data = 2'b01;
    press(1'b1, 1'b0);
    chk("add_state_b", 8'(state_code), 8'h1);
    chk("add_opa", 8'(op_a), 8'h1);
    sw_data = 2'b10;
    exec_watch("add", 2'b10, 1'b0, 2'b11, 1'b0);

    // 01 - 10 = 11, borrow
    sw_data = 2'b01;
    press(1'b1, 1'b0);
    chk("sub1_opa", 8'(op_a), 8'h1);
    chk("sub1_held_s", 8'(result_s), 8'h3);
    sw_mode = 1'b1;
    sw_data = 2'b10;
    exec_watch("sub1", 2'b10, 1'b1, 2'b11, 1'b1);

    // 11 - 01 = 10, no borrow
    sw_data = 2'b11;
    press(1'b1, 1'b0);
    sw_data = 2'b01;
    exec_watch("sub2", 2'b01, 1'b1, 2'b10, 1'b0);

    // chain a new A from SHOW
    sw_data = 2'b10;
    press(1'b1, 1'b0);
    chk("chain_state", 8'(state_code), 8'h1);
    chk("chain_opa", 8'(op_a), 8'h2);
    chk("chain_rv", 8'(result_valid), 8'd0);
    chk("chain_rs", 8'(result_s), 8'h2);
    chk("chain_rc", 8'(result_c), 8'd0);

    // clear and enter together in LOAD_B: clear wins
    sw_data = 2'b11;
    press(1'b1, 1'b1);
    chk("clr_state", 8'(state_code), 8'h0);
    chk("clr_opa", 8'(op_a), 8'd0);
    chk("clr_opb", 8'(op_b), 8'd0);
    chk("clr_opm", 8'(op_m), 8'd0);
    chk("clr_rs", 8'(result_s), 8'd0);
    chk("clr_rc", 8'(result_c), 8'd0);
    chk("clr_rv", 8'(result_valid), 8'd0);

    // switches alone change nothing
    sw_data = 2'b01;
    sw_mode = 1'b0;
    repeat (6) @(negedge clk);
    chk("sw_idle_opa", 8'(op_a), 8'd0);
    chk("sw_idle_state", 8'(state_code), 8'h0);
    press(1'b1, 1'b0);
    chk("idle2_opa", 8'(op_a), 8'h1);
    chk("idle2_state", 8'(state_code), 8'h1);

`ifdef DEBOUNCE_EN
    // 3-cycle glitch is filtered
    sw_data = 2'b10;
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("db_glitch_state", 8'(state_code), 8'h1);
    chk("db_glitch_opb", 8'(op_b), 8'd0);

    // 6-cycle press acts at edge k+6
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (6) @(negedge clk);
    btn_enter = 1'b0;
    chk("db_k5_state", 8'(state_code), 8'h1);
    @(negedge clk);
    chk("db_k6_state", 8'(state_code), 8'h2);
    chk("db_k6_opb", 8'(op_b), 8'h2);
    repeat (15) @(negedge clk);
    chk("db_once_state", 8'(state_code), 8'h3);
    chk("db_once_rs", 8'(result_s), 8'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
